// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD row feeder: matrix geometry, burst timing,
// feeder state encoding and the complex sample type.
package qrd_pkg;

    localparam int IN_WIDTH  = 14;
    localparam int H_SIZE    = 4;
    localparam int ROW_WORDS = H_SIZE + 1;
    localparam int BURST_LEN = 2 * H_SIZE;

    localparam int ROW_W  = $clog2(H_SIZE);
    localparam int COL_W  = $clog2(ROW_WORDS);
    localparam int SLOT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [IN_WIDTH-1:0] re;
        logic signed [IN_WIDTH-1:0] im;
    } sample_t;

endpackage

// File: rtl/qrd_skew_mux.sv
// Burst slot decoder: for a slot index, gives each row the buffer column it
// carries (row k runs k slots behind row 0) and the row-start flags.
module qrd_skew_mux
    import qrd_pkg::*;
(
    input  logic [SLOT_W-1:0]             slot,
    output logic [H_SIZE-1:0]             col_valid,
    output logic [H_SIZE-1:0][COL_W-1:0]  col_idx,
    output logic [H_SIZE-2:0]             row_flag
);

    // Skewed column select per row, and a flag every second slot for rows 1..3
    always_comb begin
        col_valid = '0;
        col_idx   = '0;
        row_flag  = '0;
        for (int k = 0; k < H_SIZE; k++) begin
            if (int'(slot) >= k && int'(slot) <= k + ROW_WORDS - 1) begin
                col_valid[k] = 1'b1;
                col_idx[k]   = COL_W'(int'(slot) - k);
            end
        end
        for (int k = 0; k < H_SIZE - 1; k++) begin
            row_flag[k] = (slot == SLOT_W'(2 * k));
        end
    end

endmodule

// File: rtl/qrd_row_feeder.sv
// Collects a 4x5 complex matrix (H row plus y) word by word, waits for the
// QRD core, then replays it as a skewed 8-slot burst on four row ports.
module qrd_row_feeder #(
    parameter int IN_WIDTH = 14,
    parameter int H_SIZE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_r,
    input  logic [IN_WIDTH-1:0] in_i,
    input  logic                qrd_ready,
    output logic [IN_WIDTH-1:0] row_in_1_r,
    output logic [IN_WIDTH-1:0] row_in_1_i,
    output logic [IN_WIDTH-1:0] row_in_2_r,
    output logic [IN_WIDTH-1:0] row_in_2_i,
    output logic [IN_WIDTH-1:0] row_in_3_r,
    output logic [IN_WIDTH-1:0] row_in_3_i,
    output logic [IN_WIDTH-1:0] row_in_4_r,
    output logic [IN_WIDTH-1:0] row_in_4_i,
    output logic                row_in_1_f,
    output logic                row_in_2_f,
    output logic                row_in_3_f,
    output logic                busy,
    output logic                done
);
    import qrd_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic [ROW_W-1:0]    row_cnt;
    logic [COL_W-1:0]    col_cnt;
    logic [SLOT_W-1:0]   slot;
    logic                transfer;
    logic                last_word;
    logic                load_out;
    logic [SLOT_W-1:0]   out_slot;

    logic [IN_WIDTH-1:0] buf_r [H_SIZE][ROW_WORDS];
    logic [IN_WIDTH-1:0] buf_i [H_SIZE][ROW_WORDS];

    logic [H_SIZE-1:0]            col_valid;
    logic [H_SIZE-1:0][COL_W-1:0] col_idx;
    logic [H_SIZE-2:0]            row_flag;

    logic [IN_WIDTH-1:0] out_r [H_SIZE];
    logic [IN_WIDTH-1:0] out_i [H_SIZE];
    logic [H_SIZE-2:0]   flag_q;
    logic                done_q;

    assign last_word = (row_cnt == ROW_W'(H_SIZE - 1)) && (col_cnt == COL_W'(ROW_WORDS - 1));

    // Next state plus handshake; the output registers are loaded one slot
    // ahead so that the registered data lines up with the SEND cycles
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        transfer  = 1'b0;
        load_out  = 1'b0;
        out_slot  = '0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                transfer = in_valid;
                if (in_valid && last_word) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (qrd_ready) begin
                    state_nxt = ST_SEND;
                    load_out  = 1'b1;
                end
            end
            ST_SEND: begin
                busy     = 1'b1;
                out_slot = slot + 1'b1;
                if (slot == SLOT_W'(BURST_LEN - 1)) begin
                    state_nxt = ST_LOAD;
                end else begin
                    load_out = 1'b1;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Row/column write pointer; wraps to zero after the last word of a matrix
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (transfer) begin
            if (col_cnt == COL_W'(ROW_WORDS - 1)) begin
                col_cnt <= '0;
                row_cnt <= last_word ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Burst slot counter, held at zero outside SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (state == ST_SEND) begin
            slot <= slot + 1'b1;
        end else begin
            slot <= '0;
        end
    end

    // Matrix buffer; contents are never visible outside SEND so no reset
    always_ff @(posedge clk) begin
        if (transfer && !rst) begin
            buf_r[row_cnt][col_cnt] <= in_r;
            buf_i[row_cnt][col_cnt] <= in_i;
        end
    end

    qrd_skew_mux u_skew_mux (
        .slot      (out_slot),
        .col_valid (col_valid),
        .col_idx   (col_idx),
        .row_flag  (row_flag)
    );

    // Registered row streams and flags, forced to zero whenever not bursting
    always_ff @(posedge clk) begin
        if (rst || !load_out) begin
            for (int k = 0; k < H_SIZE; k++) begin
                out_r[k] <= '0;
                out_i[k] <= '0;
            end
            flag_q <= '0;
        end else begin
            for (int k = 0; k < H_SIZE; k++) begin
                out_r[k] <= col_valid[k] ? buf_r[k][col_idx[k]] : '0;
                out_i[k] <= col_valid[k] ? buf_i[k][col_idx[k]] : '0;
            end
            flag_q <= row_flag;
        end
    end

    // Completion pulse in the first LOAD cycle after the last slot
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_SEND) && (slot == SLOT_W'(BURST_LEN - 1));
        end
    end

    assign row_in_1_r = out_r[0];
    assign row_in_1_i = out_i[0];
    assign row_in_2_r = out_r[1];
    assign row_in_2_i = out_i[1];
    assign row_in_3_r = out_r[2];
    assign row_in_3_i = out_i[2];
    assign row_in_4_r = out_r[3];
    assign row_in_4_i = out_i[3];
    assign row_in_1_f = flag_q[0];
    assign row_in_2_f = flag_q[1];
    assign row_in_3_f = flag_q[2];
    assign done       = done_q;

endmodule

// File: tb/tb_qrd_row_feeder.sv
// Directed bench for qrd_row_feeder: loads matrices, runs bursts and
// compares every slot of the skewed output against expected vectors.
module tb_qrd_row_feeder;

    localparam int W = 14;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;
    logic qrd_ready;
    logic signed [W-1:0] o_r [4];
    logic signed [W-1:0] o_i [4];
    logic [2:0] o_f;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    int mat_r [4][5];
    int mat_i [4][5];

    typedef struct packed {
        logic [2:0]       slot;
        logic [3:0][31:0] re;
        logic [3:0][31:0] im;
        logic [2:0]       f;
    } slot_vec_t;

    slot_vec_t table_a [8];
    slot_vec_t exp_slots [8];

    always #5 clk = ~clk;

    qrd_row_feeder #(.IN_WIDTH(W), .H_SIZE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_i       (in_i),
        .qrd_ready  (qrd_ready),
        .row_in_1_r (o_r[0]),
        .row_in_1_i (o_i[0]),
        .row_in_2_r (o_r[1]),
        .row_in_2_i (o_i[1]),
        .row_in_3_r (o_r[2]),
        .row_in_3_i (o_i[2]),
        .row_in_4_r (o_r[3]),
        .row_in_4_i (o_i[3]),
        .row_in_1_f (o_f[0]),
        .row_in_2_f (o_f[1]),
        .row_in_3_f (o_f[2]),
        .busy       (busy),
        .done       (done)
    );

    function automatic slot_vec_t mk(input int t,
                                     input int a0, input int a1, input int a2, input int a3,
                                     input int b0, input int b1, input int b2, input int b3,
                                     input logic [2:0] fl);
        slot_vec_t v;
        v.slot  = t[2:0];
        v.re[0] = a0; v.re[1] = a1; v.re[2] = a2; v.re[3] = a3;
        v.im[0] = b0; v.im[1] = b1; v.im[2] = b2; v.im[3] = b3;
        v.f     = fl;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive inputs for one cycle, return at the following falling edge
    task automatic applyStimulus(input logic v, input int r, input int i, input logic q);
        in_valid  = v;
        in_r      = r[W-1:0];
        in_i      = i[W-1:0];
        qrd_ready = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setMatrixA();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c < 4) begin
                    mat_r[k][c] = 4 * k + c + 1;
                    mat_i[k][c] = -(4 * k + c + 1);
                end else if (k < 3) begin
                    mat_r[k][c] = 181;
                    mat_i[k][c] = 724;
                end else begin
                    mat_r[k][c] = 724;
                    mat_i[k][c] = 181;
                end
            end
        end
    endtask

    task automatic setMatrixB();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                mat_r[k][c] = 100 * (k + 1) + c;
                mat_i[k][c] = -(50 * (k + 1) + c) - 1000;
            end
        end
    endtask

    task automatic setMatrixC();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                mat_r[k][c] = ((k + c) % 2 == 1) ? 8191 : -8192;
                mat_i[k][c] = ((k + c) % 2 == 1) ? -8192 : 8191;
                if (c == 2) begin
                    mat_r[k][c] = -1 - k;
                end
            end
        end
    endtask

    // Row k carries column t-k of its matrix row while that column exists
    task automatic buildExpected();
        for (int t = 0; t < 8; t++) begin
            exp_slots[t].slot = t[2:0];
            exp_slots[t].f    = '0;
            for (int k = 0; k < 4; k++) begin
                int d;
                d = t - k;
                exp_slots[t].re[k] = (d >= 0 && d <= 4) ? mat_r[k][d] : 0;
                exp_slots[t].im[k] = (d >= 0 && d <= 4) ? mat_i[k][d] : 0;
                if (k < 3 && t == 2 * k) begin
                    exp_slots[t].f[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic loadMatrix(input int n_words, input bit gaps, input logic q);
        int idx;
        int cyc;
        logic v;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < n_words && cyc < 400) begin
            v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = v && in_ready;
            applyStimulus(v, mat_r[idx / 5][idx % 5], mat_i[idx / 5][idx % 5], q);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("load_words_accepted", idx, n_words);
    endtask

    task automatic checkIdle(input string tag, input logic done_exp);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_row%0d_re_zero", tag, k + 1), int'(o_r[k]), 0);
            checkOutput($sformatf("%s_row%0d_im_zero", tag, k + 1), int'(o_i[k]), 0);
        end
        checkOutput($sformatf("%s_flags_zero", tag), int'(o_f), 0);
        checkOutput($sformatf("%s_busy", tag), int'(busy), 0);
        checkOutput($sformatf("%s_in_ready", tag), int'(in_ready), 1);
        checkOutput($sformatf("%s_done", tag), int'(done), int'(done_exp));
    endtask

    task automatic checkSlot(input string tag, input int t);
        int e;
        for (int k = 0; k < 4; k++) begin
            e = exp_slots[t].re[k];
            checkOutput($sformatf("%s_t%0d_row%0d_re", tag, t, k + 1), int'(o_r[k]), e);
            e = exp_slots[t].im[k];
            checkOutput($sformatf("%s_t%0d_row%0d_im", tag, t, k + 1), int'(o_i[k]), e);
        end
        checkOutput($sformatf("%s_t%0d_flags", tag, t), int'(o_f), int'(exp_slots[t].f));
        checkOutput($sformatf("%s_t%0d_busy", tag, t), int'(busy), 1);
        checkOutput($sformatf("%s_t%0d_in_ready", tag, t), int'(in_ready), 0);
    endtask

    // Called in WAIT; garbage words are offered throughout to prove they are ignored
    task automatic checkBurst(input string tag, input int drop_at, input int rst_at);
        applyStimulus(1'b1, 'h1555, 'h0AAA, 1'b1);
        for (int t = 0; t < 8; t++) begin
            checkSlot(tag, t);
            if (t == rst_at) begin
                rst = 1'b1;
                applyStimulus(1'b1, 'h1555, 'h0AAA, 1'b1);
                rst = 1'b0;
                checkIdle({tag, "_rst"}, 1'b0);
                for (int j = 0; j < 3; j++) begin
                    applyStimulus(1'b0, 0, 0, 1'b0);
                    checkIdle($sformatf("%s_rst_quiet%0d", tag, j), 1'b0);
                end
                return;
            end
            applyStimulus(1'b1, 'h1555, 'h0AAA, (t < drop_at) ? 1'b1 : 1'b0);
        end
        in_valid  = 1'b0;
        qrd_ready = 1'b0;
        checkIdle({tag, "_done"}, 1'b1);
    endtask

    task automatic stepDoneLow(input string tag);
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput({tag, "_done_low"}, int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        table_a[0] = mk(0,   1, 0,   0,   0,   -1,   0,   0,   0, 3'b001);
        table_a[1] = mk(1,   2, 5,   0,   0,   -2,  -5,   0,   0, 3'b000);
        table_a[2] = mk(2,   3, 6,   9,   0,   -3,  -6,  -9,   0, 3'b010);
        table_a[3] = mk(3,   4, 7,  10,  13,   -4,  -7, -10, -13, 3'b000);
        table_a[4] = mk(4, 181, 8,  11,  14,  724,  -8, -11, -14, 3'b100);
        table_a[5] = mk(5,   0, 181, 12,  15,   0, 724, -12, -15, 3'b000);
        table_a[6] = mk(6,   0, 0, 181,  16,    0,   0, 724, -16, 3'b000);
        table_a[7] = mk(7,   0, 0,   0, 724,    0,   0,   0, 181, 3'b000);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        qrd_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset", 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkIdle("post_reset", 1'b0);

        $display("[TB] basic burst");
        setMatrixA();
        loadMatrix(20, 1'b0, 1'b0);
        checkOutput("a_wait_busy", int'(busy), 1);
        checkOutput("a_wait_in_ready", int'(in_ready), 0);
        for (int t = 0; t < 8; t++) exp_slots[t] = table_a[t];
        checkBurst("a", 0, -1);
        stepDoneLow("a");

        $display("[TB] long wait for core");
        loadMatrix(20, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, 'h0123, 'h0321, 1'b0);
            checkOutput($sformatf("wait%0d_busy", j), int'(busy), 1);
            checkOutput($sformatf("wait%0d_in_ready", j), int'(in_ready), 0);
            checkOutput($sformatf("wait%0d_row1_re", j), int'(o_r[0]), 0);
            checkOutput($sformatf("wait%0d_row4_im", j), int'(o_i[3]), 0);
            checkOutput($sformatf("wait%0d_flags", j), int'(o_f), 0);
            checkOutput($sformatf("wait%0d_done", j), int'(done), 0);
        end
        in_valid = 1'b0;
        checkBurst("wait", 0, -1);
        stepDoneLow("wait");

        $display("[TB] gapped load, core ready early, drop at t=3");
        setMatrixB();
        loadMatrix(20, 1'b1, 1'b1);
        checkOutput("gap_wait_in_ready", int'(in_ready), 0);
        checkOutput("gap_wait_busy", int'(busy), 1);
        buildExpected();
        checkBurst("gap", 3, -1);

        $display("[TB] back-to-back extremes, reset at t=4");
        setMatrixC();
        loadMatrix(20, 1'b0, 1'b0);
        buildExpected();
        checkBurst("ext", 8, 4);
        setMatrixB();
        loadMatrix(20, 1'b0, 1'b0);
        buildExpected();
        checkBurst("after_rst", 0, -1);
        stepDoneLow("after_rst");

        $display("[TB] reset in WAIT and mid-load");
        setMatrixA();
        loadMatrix(20, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b1);
        rst = 1'b0;
        checkIdle("wait_rst", 1'b0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 0, 0, 1'b1);
            checkIdle($sformatf("wait_rst_quiet%0d", j), 1'b0);
        end
        qrd_ready = 1'b0;
        loadMatrix(7, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        checkIdle("load_rst", 1'b0);
        setMatrixC();
        loadMatrix(20, 1'b0, 1'b0);
        buildExpected();
        checkBurst("reload", 0, -1);
        stepDoneLow("reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qrd_row_feeder.md
QRD_ROW_FEEDER -- requirements
Module: qrd_row_feeder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 14, meaning the two's-complement width of each real/imag sample.
REQ-002 SHALL have parameter H_SIZE, default 4, meaning the matrix order; the design need only support 4.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  feeder accepts a word this cycle.
REQ-008 in_r, in_i  input  IN_WIDTH each  serial matrix word, row-major, 5 words per row: h[k][0..3], then y[k].
REQ-009 qrd_ready  input  1  QRD core ready for a new matrix.
REQ-010 row_in_k_r, row_in_k_i (k=1..4)  output  IN_WIDTH each  skewed row stream to the QRD core.
REQ-011 row_in_k_f (k=1..3)  output  1  row-start flag to the QRD core; row 4 has no flag.
REQ-012 busy  output  1  high in WAIT or SEND.
REQ-013 done  output  1  one-cycle pulse after a burst completes.

Function
REQ-014 SHALL implement three states: LOAD, WAIT and SEND.
REQ-015 LOAD: in_ready=1; a word transfers when in_valid&&in_ready and is written to buffer slot [row][col] given by a 0..19 word counter.
REQ-016 The transfer of word 19 SHALL move the state to WAIT on the same edge and clear the word counter.
REQ-017 WAIT: in_ready=0; qrd_ready is sampled each cycle, and qrd_ready=1 moves the state to SEND at the next edge.
REQ-018 SEND: an 8-slot counter t=0..7 runs, one slot per cycle, starting at the first SEND cycle; the burst is non-stallable and qrd_ready is ignored in SEND.
REQ-019 In slot t, row k (k=1..4) SHALL carry buffer[k-1][t-(k-1)] when 0 <= t-(k-1) <= 4, and zero otherwise.
REQ-020 row_in_k_f SHALL be 1 only in slot t=2(k-1), i.e. row 1 at t=0, row 2 at t=2, row 3 at t=4.
REQ-021 After slot 7 the state SHALL return to LOAD, and done SHALL pulse for exactly the first LOAD cycle.
REQ-022 All data and flag outputs SHALL be registered and SHALL be zero outside SEND.
REQ-023 in_valid outside LOAD SHALL be ignored and SHALL NOT alter the buffer or counters.
REQ-024 Samples SHALL pass through bit-exact, with no arithmetic, rounding or sign change.
REQ-025 A back-to-back matrix MAY begin loading in the done cycle; its loading SHALL NOT overlap the previous burst.

Reset
REQ-026 rst=1 SHALL force LOAD, clear all counters, zero all row outputs and flags, and set busy=0 and done=0; in_ready=1 from the first cycle after reset.
REQ-027 Reset asserted mid-LOAD, in WAIT, or mid-SEND SHALL abort the operation immediately, discard partial data, and emit no further burst slots.
REQ-028 Buffer contents need not be cleared by reset; outputs SHALL never expose stale data outside SEND.

Structure
REQ-029 A shared package qrd_pkg SHALL hold IN_WIDTH, H_SIZE, ROW_WORDS=H_SIZE+1, BURST_LEN=2*H_SIZE, the state enum, and the sample typedef (signed real/imag pair).
REQ-030 One sub-module, qrd_skew_mux, SHALL be natural: a combinational slot/row-to-buffer-index selector plus flag decode, instantiated once.
REQ-031 The total size SHALL be about 150-250 lines of RTL.

Verification
REQ-032 Load 20 words with H row0 = 1,2,3,4 (real) and y = 181+724j, row3 y = 724+181j, then pulse qrd_ready -> row 1 shows 1,2,3,4,181 in t=0..4; row 4 shows its H row then 724 in t=3..7; flags appear at t=0,2,4.
REQ-033 in_valid toggling randomly during load, with qrd_ready held high -> exactly 20 accepted words, buffer order preserved, and SEND starts 1 cycle after WAIT is entered.
REQ-034 qrd_ready held low for 10 cycles after load -> the state stays in WAIT, in_ready=0, outputs stay zero, busy=1; releasing qrd_ready gives the SEND pattern of REQ-032.
REQ-035 qrd_ready deasserted at t=3 of SEND -> the burst completes unchanged, and done pulses once at the cycle after t=7.
REQ-036 rst asserted at t=4 of SEND -> all outputs are zero from the next cycle and in_ready=1; a new load of 20 words produces a correct full burst.
REQ-037 Negative extremes -8192 and 8191 (IN_WIDTH=14) in real and imag -> reproduced bit-exact on the outputs.
